// File: rtl/icp_pkg.sv
// Shared definitions for the ICP program loader: memory op codes, default
// widths, loader state encoding and the ASCII bytes the parser recognises.
package icp_pkg;

  localparam int unsigned ICP_ADDR_W = 13;
  localparam int unsigned ICP_DATA_W = 64;

  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_READ  = 2'd1;
  localparam logic [1:0] MEM_OP_WRITE = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StParse,
    StWrite,
    StDone,
    StError
  } icp_state_e;

  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_EOT   = 8'h04;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/icp_dec_accum.sv
// Decimal accumulator: acc <= acc*10 + digit, with an unsigned overflow flag
// computed from the current accumulator and the presented digit.
module icp_dec_accum #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [3:0]        digit_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W+3:0] acc_ext;
  logic [DATA_W+3:0] mac;

  // Multiply-accumulate in a 4-bit-wider datapath so the carry-out is visible.
  always_comb begin
    acc_ext = {4'b0000, acc_q};
    mac     = (acc_ext << 3) + (acc_ext << 1) + {{DATA_W{1'b0}}, digit_i};
  end

  assign acc_o = acc_q;
  assign ovf_o = |mac[DATA_W+3:DATA_W];

  // Accumulator register; clear has priority over load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= mac[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/icp_loader.sv
// ASCII program loader: parses comma-separated signed decimal words from a
// byte stream and writes them to consecutive memory addresses from 0.
module icp_loader
  import icp_pkg::*;
#(
  parameter int unsigned ADDR_W = ICP_ADDR_W,
  parameter int unsigned DATA_W = ICP_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic [1:0]        o_op,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_word_count
);

  icp_state_e        state_q, state_d;
  logic              neg_q, neg_d;
  logic              seen_q, seen_d;
  logic              term_q, term_d;   // current field ended the program
  logic [ADDR_W:0]   cnt_q, cnt_d;     // words written; also the next write address
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              acc_clear;
  logic              acc_load;
  logic [DATA_W-1:0] acc;
  logic              acc_ovf;

  icp_dec_accum #(
    .DATA_W (DATA_W)
  ) u_dec_accum (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clear_i (acc_clear),
    .load_i  (acc_load),
    .digit_i (i_byte[3:0]),
    .acc_o   (acc),
    .ovf_o   (acc_ovf)
  );

  // Next-state logic: byte decode in PARSE, bookkeeping in WRITE, restart elsewhere.
  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    seen_d    = seen_q;
    term_d    = term_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    acc_clear = 1'b0;
    acc_load  = 1'b0;

    case (state_q)
      StIdle, StDone, StError: begin
        if (i_start) begin
          state_d   = StParse;
          neg_d     = 1'b0;
          seen_d    = 1'b0;
          term_d    = 1'b0;
          cnt_d     = '0;
          acc_clear = 1'b1;
        end
      end

      StParse: begin
        if (i_byte_valid) begin
          if (is_digit(i_byte)) begin
            if (acc_ovf) begin
              state_d = StError;
            end else begin
              acc_load = 1'b1;
              seen_d   = 1'b1;
            end
          end else begin
            case (i_byte)
              ASCII_MINUS: begin
                if (seen_q) state_d = StError;
                else        neg_d   = 1'b1;
              end
              ASCII_SPACE, ASCII_CR, ASCII_TAB: begin
                // whitespace is dropped anywhere
              end
              ASCII_COMMA, ASCII_LF, ASCII_EOT: begin
                if (!seen_q) begin
                  // empty field: error for ',', clean end for a terminator
                  state_d = (i_byte == ASCII_COMMA) ? StError : StDone;
                end else if (cnt_q[ADDR_W]) begin
                  // memory full; refuse to wrap the address
                  state_d = StError;
                end else begin
                  state_d = StWrite;
                  term_d  = (i_byte != ASCII_COMMA);
                  addr_d  = cnt_q[ADDR_W-1:0];
                  data_d  = neg_q ? -acc : acc;
                end
              end
              default: state_d = StError;
            endcase
          end
        end
      end

      StWrite: begin
        cnt_d     = cnt_q + 1'b1;
        acc_clear = 1'b1;
        neg_d     = 1'b0;
        seen_d    = 1'b0;
        state_d   = term_q ? StDone : StParse;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      neg_q   <= 1'b0;
      seen_q  <= 1'b0;
      term_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      seen_q  <= seen_d;
      term_q  <= term_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_byte_ready = (state_q == StParse);
  assign o_busy       = (state_q == StParse) || (state_q == StWrite);
  assign o_done       = (state_q == StDone);
  assign o_error      = (state_q == StError);
  assign o_op         = (state_q == StWrite) ? MEM_OP_WRITE : MEM_OP_NONE;
  assign o_addr       = addr_q;
  assign o_data       = data_q;
  assign o_word_count = cnt_q;

endmodule

// File: tb/tb_icp_loader.sv
// Bench for icp_loader: directed vector table, randomized programs against a
// parsing reference model, and hand-written latency / reset sequences.
module tb_icp_loader;

  localparam int AW = 13;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    bbyte = 8'h00;
  logic          bvalid = 1'b0;
  logic          o_byte_ready;
  logic [1:0]    o_op;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [AW:0]   o_word_count;

  always #5 clk = ~clk;

  icp_loader #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_byte       (bbyte),
    .i_byte_valid (bvalid),
    .o_byte_ready (o_byte_ready),
    .o_op         (o_op),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  logic [DW-1:0] exp_q[$];
  bit            m_done;
  bit            m_err;
  int            m_used;

  typedef struct packed {
    logic          gaps;
    logic [AW:0]   cnt;
    logic          done;
    logic          err;
    logic [DW-1:0] last;
  } vec_t;

  localparam int NV = 9;
  vec_t  vecs[NV];
  string txt[NV];

  // Write monitor; any op other than NONE/WRITE is a failure.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_op == 2'd2) begin
        got_addr.push_back(o_addr);
        got_data.push_back(o_data);
      end else if (o_op != 2'd0) begin
        errors++;
        $display("FAIL op_encoding act=%0d req=0_or_2", o_op);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " op"}, 64'(o_op), 0);
    chk({tag, " addr"}, 64'(o_addr), 0);
    chk({tag, " data"}, o_data, 0);
    chk({tag, " busy"}, 64'(o_busy), 0);
    chk({tag, " done"}, 64'(o_done), 0);
    chk({tag, " error"}, 64'(o_error), 0);
    chk({tag, " wcount"}, 64'(o_word_count), 0);
    chk({tag, " ready"}, 64'(o_byte_ready), 0);
  endtask

  // Offer bytes in order; stop once the loader refuses a byte for 8 cycles.
  task automatic send_str(input string s, input bit gaps, output int used);
    bit took;
    used = 0;
    for (int i = 0; i < s.len(); i++) begin
      took = 1'b0;
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      bbyte  = s[i];
      bvalid = 1'b1;
      for (int n = 0; n < 8 && !took; n++) begin
        @(negedge clk);
        if (o_byte_ready) took = 1'b1;
        tick();
      end
      bvalid = 1'b0;
      if (!took) break;
      used++;
    end
  endtask

  // Reference: field-by-field parse using wide arithmetic.
  task automatic model(input string s);
    logic [127:0] acc;
    logic [127:0] v;
    logic [63:0]  a64;
    logic [7:0]   c;
    bit           neg;
    bit           seen;
    acc = 0; neg = 0; seen = 0;
    m_done = 0; m_err = 0; m_used = 0;
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (m_done || m_err) break;
      c = s[i];
      m_used++;
      if (c >= 8'h30 && c <= 8'h39) begin
        v = acc * 10 + 128'(c - 8'h30);
        if (v[127:64] != 0) m_err = 1;
        else acc = v;
        seen = 1;
      end else if (c == 8'h2D) begin
        if (seen) m_err = 1;
        else neg = 1;
      end else if (c == 8'h20 || c == 8'h0D || c == 8'h09) begin
        // ignored
      end else if (c == 8'h2C || c == 8'h0A || c == 8'h04) begin
        if (!seen) begin
          if (c == 8'h2C) m_err = 1;
          else m_done = 1;
        end else if (exp_q.size() >= (1 << AW)) begin
          m_err = 1;
        end else begin
          a64 = acc[63:0];
          exp_q.push_back(neg ? (64'd0 - a64) : a64);
          acc = 0; neg = 0; seen = 0;
          if (c != 8'h2C) m_done = 1;
        end
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic compare_writes(input string name);
    int n;
    chk({name, " nwrites"}, 64'(got_data.size()), 64'(exp_q.size()));
    n = (got_data.size() < exp_q.size()) ? got_data.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s addr[%0d]", name, i), 64'(got_addr[i]), 64'(i));
      chk($sformatf("%s data[%0d]", name, i), got_data[i], exp_q[i]);
    end
  endtask

  task automatic run_case(input string name, input string s, input bit gaps);
    int used;
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_str(s, gaps, used);
    for (int k = 0; k < 10 && o_busy; k++) tick();
    model(s);
    chk({name, " busy"}, 64'(o_busy), 0);
    chk({name, " done"}, 64'(o_done), 64'(m_done));
    chk({name, " error"}, 64'(o_error), 64'(m_err));
    chk({name, " ready"}, 64'(o_byte_ready), 0);
    chk({name, " wcount"}, 64'(o_word_count), 64'(exp_q.size()));
    chk({name, " consumed"}, 64'(used), 64'(m_used));
    compare_writes(name);
  endtask

  function automatic string gen_prog();
    string s;
    int    nf;
    int    kind;
    longint unsigned v;
    s  = "";
    nf = $urandom_range(1, 5);
    for (int f = 0; f < nf; f++) begin
      if ($urandom_range(0, 3) == 0) s = {s, "-"};
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        s = {s, $sformatf("%0d", $urandom_range(0, 999))};
      end else if (kind < 8) begin
        v = {$urandom(), $urandom()};
        s = {s, $sformatf("%0d", v)};
      end else if (kind == 8) begin
        s = {s, " 42\t"};
      end else begin
        s = {s, "99999999999999999999"};
      end
      if (f < nf - 1) begin
        kind = $urandom_range(0, 15);
        if (kind == 0)      s = {s, ",,"};
        else if (kind == 1) s = {s, "q,"};
        else if (kind == 2) s = {s, "3-,"};
        else                s = {s, ","};
      end
    end
    if ($urandom_range(0, 1) == 1) s = {s, "\n"};
    else                           s = {s, "\004"};
    return s;
  endfunction

  initial begin
    int used;

    txt[0] = "1,9,10,3,2,3,11,0,99,30,40,50\n";
    vecs[0] = '{gaps: 1'b0, cnt: 14'd12, done: 1'b1, err: 1'b0, last: 64'd50};
    txt[1] = "3,-7 , 0\n";
    vecs[1] = '{gaps: 1'b1, cnt: 14'd3, done: 1'b1, err: 1'b0, last: 64'd0};
    txt[2] = "5,,6\n";
    vecs[2] = '{gaps: 1'b0, cnt: 14'd1, done: 1'b0, err: 1'b1, last: 64'd5};
    txt[3] = "18446744073709551616,";
    vecs[3] = '{gaps: 1'b0, cnt: 14'd0, done: 1'b0, err: 1'b1, last: 64'd0};
    txt[4] = "18446744073709551615\n";
    vecs[4] = '{gaps: 1'b1, cnt: 14'd1, done: 1'b1, err: 1'b0, last: 64'hFFFF_FFFF_FFFF_FFFF};
    txt[5] = "1-2\n";
    vecs[5] = '{gaps: 1'b0, cnt: 14'd0, done: 1'b0, err: 1'b1, last: 64'd0};
    txt[6] = "\n";
    vecs[6] = '{gaps: 1'b0, cnt: 14'd0, done: 1'b1, err: 1'b0, last: 64'd0};
    txt[7] = "12\r,\t-5\004";
    vecs[7] = '{gaps: 1'b1, cnt: 14'd2, done: 1'b1, err: 1'b0, last: 64'hFFFF_FFFF_FFFF_FFFB};
    txt[8] = "7x";
    vecs[8] = '{gaps: 1'b0, cnt: 14'd0, done: 1'b0, err: 1'b1, last: 64'd0};

    // Reset state, then idle until start.
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset busy", 64'(o_busy), 0);
    chk("post_reset ready", 64'(o_byte_ready), 0);

    // Directed vectors.
    for (int i = 0; i < NV; i++) begin
      run_case($sformatf("vec%0d", i), txt[i], vecs[i].gaps);
      chk($sformatf("vec%0d tbl_wcount", i), 64'(o_word_count), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d tbl_done", i), 64'(o_done), 64'(vecs[i].done));
      chk($sformatf("vec%0d tbl_error", i), 64'(o_error), 64'(vecs[i].err));
      if (vecs[i].cnt != 0 && got_data.size() != 0)
        chk($sformatf("vec%0d tbl_last", i), got_data[got_data.size()-1], vecs[i].last);
    end

    // Write latency, held outputs, and start ignored while busy.
    got_addr.delete();
    got_data.delete();
    pulse_start();
    bbyte = 8'h37; bvalid = 1'b1;
    @(negedge clk); chk("lat ready_digit", 64'(o_byte_ready), 1);
    tick();
    bbyte = 8'h2C;
    @(negedge clk); chk("lat ready_comma", 64'(o_byte_ready), 1);
    tick();
    bvalid = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    chk("lat write_op", 64'(o_op), 2);
    chk("lat write_addr", 64'(o_addr), 0);
    chk("lat write_data", o_data, 7);
    chk("lat write_ready", 64'(o_byte_ready), 0);
    chk("lat write_busy", 64'(o_busy), 1);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("lat after_ready", 64'(o_byte_ready), 1);
    chk("lat after_op", 64'(o_op), 0);
    chk("lat after_wcount", 64'(o_word_count), 1);
    chk("lat after_data_hold", o_data, 7);
    tick();
    send_str("8\n", 1'b0, used);
    for (int k = 0; k < 10 && o_busy; k++) tick();
    exp_q.delete();
    exp_q.push_back(64'd7);
    exp_q.push_back(64'd8);
    compare_writes("lat");
    chk("lat done", 64'(o_done), 1);
    chk("lat wcount", 64'(o_word_count), 2);

    // Reset in the middle of a field aborts with no write afterwards.
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_str("12", 1'b0, used);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("midreset idle_busy", 64'(o_busy), 0);
    chk("midreset no_write", 64'(got_data.size()), 0);
    run_case("after_reset", "4\n", 1'b0);

    // Randomized programs against the reference model.
    for (int r = 0; r < 25; r++) begin
      run_case($sformatf("rand%0d", r), gen_prog(), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icp_loader.md
ICP_LOADER -- requirements
Module: icp_loader

Interface
REQ-001 Parameter ADDR_W, default 13, memory word-address width.
REQ-002 Parameter DATA_W, default 64, memory word width.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_start  input  1  one-cycle pulse that begins a program load.
REQ-006 i_byte  input  8  ASCII program text byte.
REQ-007 i_byte_valid  input  1  i_byte holds a valid byte.
REQ-008 o_byte_ready  output  1  loader accepts i_byte this cycle.
REQ-009 o_op  output  2  memory port op: 0 NONE, 1 READ (never driven), 2 WRITE.
REQ-010 o_addr  output  ADDR_W  memory write address.
REQ-011 o_data  output  DATA_W  memory write data.
REQ-012 o_busy  output  1  load in progress; the processor is held off while high.
REQ-013 o_done  output  1  load finished cleanly; level.
REQ-014 o_error  output  1  load aborted; level.
REQ-015 o_word_count  output  ADDR_W+1  number of words written in the current or last load.

Function
REQ-016 States: IDLE, PARSE, WRITE, DONE, ERROR; o_busy SHALL be 1 exactly in PARSE and WRITE.
REQ-017 i_start in IDLE, DONE or ERROR SHALL enter PARSE on the next cycle, clear o_done, o_error, o_word_count, the accumulator and the write address. i_start in PARSE or WRITE SHALL be ignored.
REQ-018 o_byte_ready SHALL be 1 only in PARSE. A byte is consumed on cycles where i_byte_valid && o_byte_ready.
REQ-019 Digit '0'-'9': acc <= acc*10 + digit, modulo 2^DATA_W; set digit_seen.
REQ-020 '-' before any digit of the current field sets neg. '-' in any other position SHALL enter ERROR.
REQ-021 ' ', '\r', '\t' SHALL be consumed and ignored.
REQ-022 ',' with digit_seen SHALL enter WRITE. ',' without digit_seen SHALL enter ERROR.
REQ-023 '\n' or 0x04 with digit_seen SHALL enter WRITE, then DONE. Without digit_seen it SHALL enter DONE directly; this covers a trailing newline or an empty program.
REQ-024 Any other byte SHALL enter ERROR.
REQ-025 WRITE lasts exactly one cycle, with these registered outputs:
- o_op=2
- o_addr = write address
- o_data = neg ? -acc : acc (two's complement)
Then: address+1, o_word_count+1, acc/neg/digit_seen cleared; return to PARSE, or go to DONE if the field was terminated by '\n'/0x04.
REQ-026 Latency: the terminator byte is consumed at edge N; WRITE is visible during cycle N+1; o_byte_ready returns during cycle N+2.
REQ-027 o_op SHALL be 0 in every state except WRITE. o_addr and o_data SHALL hold their last values outside WRITE.
REQ-028 A terminator that would write when o_word_count == 2^ADDR_W SHALL enter ERROR with no write; the address never wraps.
REQ-029 A digit whose multiply-accumulate overflows DATA_W bits (unsigned) SHALL enter ERROR.
REQ-030 DONE and ERROR hold until i_start. In both, o_byte_ready=0 and o_op=0.

Reset
REQ-031 While i_rst_n=0, state SHALL be IDLE and every output SHALL be 0: o_op, o_addr, o_data, o_busy, o_done, o_error, o_word_count, o_byte_ready.
REQ-032 Reset asserted mid-load SHALL abort it immediately; no partial WRITE completes after deassertion.
REQ-033 After deassertion the loader stays in IDLE until i_start.

Structure
REQ-034 Shared package icp_pkg SHALL hold:
- memory op encodings MEM_OP_NONE/READ/WRITE
- ADDR_W/DATA_W defaults
- loader state enum
- ASCII constants for ',', '-', '\n', 0x04
REQ-035 A sub-module icp_dec_accum SHALL implement acc*10+digit with an overflow flag, clear and load controls.

Verification
REQ-036 Start, then stream "1,9,10,3,2,3,11,0,99,30,40,50\n" with valid held high -> 12 WRITEs to addresses 0..11 with data 1,9,10,3,2,3,11,0,99,30,40,50; o_word_count=12; o_done=1; o_error=0.
REQ-037 Stream "3,-7 , 0\n" with random valid gaps -> WRITEs 3, 0xFFFFFFFFFFFFFFF9, 0 at addresses 0..2; o_done=1.
REQ-038 Stream "5,,6\n" -> WRITE 5 at address 0, then o_error=1 with o_word_count=1 and no further WRITE; o_byte_ready=0.
REQ-039 Stream "18446744073709551616," -> o_error=1, no WRITE. Then "18446744073709551615\n" after i_start -> one WRITE of all-ones.
REQ-040 Pulse i_rst_n low two cycles after "12" digits -> all outputs 0 immediately. A fresh i_start followed by "4\n" -> one WRITE 4 at address 0.
REQ-041 Stream "1-2\n" -> o_error=1. Then i_start with "\n" only -> o_done=1, o_word_count=0, no WRITE.
